liteeth_sram_fifo_ctrl: RTL and testbench

Controller that turns the `liteeth_32x384_8_sram` macro (1RW port 0, 1R port 1) into a single-clock 32-bit valid/ready FIFO. Port 0 is used only for writes; port 1 is used only for reads. A 2-entry output buffer hides the registered read latency and sustains one word per cycle. The block sits between the MAC AXI ingress packer and the MII egress serializer. After reset it optionally zero-clears the array.

---
 rtl/liteeth_sram_fifo_ctrl_if.sv | 12 +
 rtl/liteeth_sram_fifo_ctrl.sv | 129 ++++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/liteeth_sram_fifo_ctrl_if.sv
// Valid/ready word stream used for both the ingress and egress sides of the SRAM FIFO.
// The master drives valid/data and the slave drives ready.
interface liteeth_sram_fifo_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Single-clock valid/ready FIFO built on a 1RW + 1R SRAM macro: port 0 writes, port 1 reads,
// and a 2-entry output buffer absorbs the registered read latency.
module liteeth_sram_fifo_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 384,
  parameter int ADDR_W     = 9,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstb,
  liteeth_sram_fifo_ctrl_if.slave  ingress,
  liteeth_sram_fifo_ctrl_if.master egress,
  input  logic                     flush,
  output logic                     busy,
  output logic [9:0]               level,
  output logic                     sram_csb0,
  output logic                     sram_web0,
  output logic [3:0]               sram_wmask0,
  output logic [ADDR_W-1:0]        sram_addr0,
  output logic [DATA_W-1:0]        sram_din0,
  output logic                     sram_csb1,
  output logic [ADDR_W-1:0]        sram_addr1,
  input  logic [DATA_W-1:0]        sram_dout1
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [9:0]        DEPTH_CNT   = 10'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam state_t            RESET_STATE = INIT_CLEAR ? INIT : RUN;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_addr, wr_ptr, rd_ptr;
  logic [9:0]        mem_count;
  logic              inflight;
  logic [DATA_W-1:0] buf_mem [2];
  logic              buf_head, buf_tail;
  logic [1:0]        buf_cnt;
  logic              run, write, issue, capture, pop, drop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_addr == LAST_ADDR) state_next = RUN;
  end

  // Reads are allowed only while the buffer plus the word in flight, net of this cycle's pop, has room.
  always_comb begin
    egress.valid  = buf_cnt != 2'd0;
    egress.data   = buf_mem[buf_head];
    run           = (state == RUN) && rstb;
    busy          = state == INIT;
    ingress.ready = run && mem_count != DEPTH_CNT && !flush;
    write         = ingress.valid && ingress.ready;
    pop           = egress.valid && egress.ready;
    issue         = run && !flush && mem_count != 10'd0 &&
                    (({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    drop          = flush && inflight;
    capture       = inflight && !drop;

    sram_wmask0 = 4'hF;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (state == INIT && rstb) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = init_addr;
    end else if (write) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = wr_ptr;
      sram_din0  = ingress.data;
    end

    sram_csb1  = !issue;
    sram_addr1 = issue ? rd_ptr : '0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      init_addr  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      inflight   <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_head   <= 1'b0;
      buf_tail   <= 1'b0;
      buf_cnt    <= '0;
      level      <= '0;
    end else if (state == INIT) begin
      init_addr <= init_addr + 1'b1;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      buf_head  <= 1'b0;
      buf_tail  <= 1'b0;
      buf_cnt   <= '0;
      level     <= '0;
    end else begin
      if (write) wr_ptr <= ptr_inc(wr_ptr);
      if (issue) rd_ptr <= ptr_inc(rd_ptr);
      mem_count <= mem_count + 10'(write) - 10'(issue);
      inflight  <= issue;
      if (capture) begin
        buf_mem[buf_tail] <= sram_dout1;
        buf_tail          <= ~buf_tail;
      end
      if (pop) buf_head <= ~buf_head;
      buf_cnt <= buf_cnt + 2'(capture) - 2'(pop);
      level   <= level + 10'(write) - 10'(pop);
    end
  end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Directed bench for the SRAM FIFO controller: behavioural SRAM model, scoreboard queue
// for egress ordering, and hand-computed checks for init, latency, fill, wrap, flush and throughput.
module tb_liteeth_sram_fifo_ctrl;

  localparam int DEPTH = 384;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [9:0]  level;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout1;
  logic [31:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  liteeth_sram_fifo_ctrl_if #(.DATA_W(32)) in_bus ();
  liteeth_sram_fifo_ctrl_if #(.DATA_W(32)) out_bus ();

  liteeth_sram_fifo_ctrl #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(9), .INIT_CLEAR(1'b1)
  ) dut (
    .clk(clk), .rstb(rstb), .ingress(in_bus), .egress(out_bus), .flush(flush),
    .busy(busy), .level(level),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Behavioural model of the macro: synchronous write on port 0, registered read on port 1.
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  int init_writes = 0, max0 = 0, max1 = 0, prev0 = -1, prev1 = -1;
  bit init_bad = 0, ov_in_init = 0, wrap0 = 0, wrap1 = 0;

  always @(posedge clk) begin
    if (rstb && busy) begin
      if (!sram_csb0 && !sram_web0) begin
        if (sram_addr0 !== 9'(init_writes) || sram_din0 !== 32'h0) init_bad = 1;
        init_writes++;
      end
      if (out_bus.valid) ov_in_init = 1;
    end else if (rstb) begin
      if (!sram_csb0) begin
        if (int'(sram_addr0) > max0) max0 = int'(sram_addr0);
        if (prev0 == DEPTH - 1 && sram_addr0 == 9'd0) wrap0 = 1;
        prev0 = int'(sram_addr0);
      end
      if (!sram_csb1) begin
        if (int'(sram_addr1) > max1) max1 = int'(sram_addr1);
        if (prev1 == DEPTH - 1 && sram_addr1 == 9'd0) wrap1 = 1;
        prev1 = int'(sram_addr1);
      end
    end
  end

  int          n_cmp = 0, n_err = 0, accepts = 0, pops = 0;
  logic [31:0] q [$];
  logic        acc, obs_in_ready, obs_out_valid, obs_busy, obs_csb1;
  logic [31:0] obs_out_data;
  logic [9:0]  obs_level;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, score handshakes, wait for next falling edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    logic popd;
    in_bus.valid  = iv;
    in_bus.data   = id;
    out_bus.ready = ordy;
    flush         = fl;
    #1;
    obs_in_ready  = in_bus.ready;
    obs_out_valid = out_bus.valid;
    obs_out_data  = out_bus.data;
    obs_level     = level;
    obs_busy      = busy;
    obs_csb1      = sram_csb1;
    acc  = iv && obs_in_ready;
    popd = obs_out_valid && ordy;
    if (acc) begin
      q.push_back(id);
      accepts++;
    end
    if (popd) begin
      pops++;
      checkOutput("pop_has_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) checkOutput("pop_data", obs_out_data, q.pop_front());
    end
    if (fl) q.delete();
    @(negedge clk);
  endtask

  initial begin
    int first_ready, lat, lvl_first, sent, n;
    bit busy_before;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_in_ready", in_bus.ready, 0);
    checkOutput("rst_out_valid", out_bus.valid, 0);
    checkOutput("rst_out_data", out_bus.data, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_csb0", sram_csb0, 1);
    checkOutput("rst_web0", sram_web0, 1);
    checkOutput("rst_csb1", sram_csb1, 1);
    checkOutput("rst_addr0", sram_addr0, 0);
    checkOutput("rst_wmask0", sram_wmask0, 4'hF);

    // Init: in_ready must first rise in cycle DEPTH after release.
    rstb = 1'b1;
    first_ready = -1;
    busy_before = 0;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(0, 0, 0, 0);
      if (obs_in_ready) begin
        first_ready = k;
        break;
      end
      busy_before = obs_busy;
    end
    checkOutput("init_ready_cycle", 64'(first_ready), 64'(DEPTH));
    checkOutput("init_busy_low", obs_busy, 0);
    checkOutput("init_busy_before", busy_before, 1);
    checkOutput("init_writes", 64'(init_writes), 64'(DEPTH));
    checkOutput("init_addr_data", init_bad, 0);
    checkOutput("init_out_valid", ov_in_init, 0);

    // Single word: out_valid exactly 3 cycles after acceptance.
    applyStimulus(1, 32'hDEADBEEF, 1, 0);
    checkOutput("lat_accept", acc, 1);
    lat = -1;
    lvl_first = -1;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 1, 0);
      if (k == 1) lvl_first = int'(obs_level);
      if (obs_out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("lat_cycles", 64'(lat), 64'd3);
    checkOutput("lat_level_1", 64'(lvl_first), 64'd1);
    checkOutput("lat_data", obs_out_data, 32'hDEADBEEF);
    checkOutput("lat_level_0", level, 0);

    // Fill with egress stalled: 384 in SRAM + 2 in the buffer.
    accepts = 0;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1, 32'(n), 0, 0);
      if (acc) n++;
    end
    checkOutput("fill_accepted", 64'(accepts), 64'd386);
    checkOutput("fill_level", obs_level, 10'd386);
    checkOutput("fill_in_ready", obs_in_ready, 0);
    checkOutput("fill_head_data", obs_out_data, 32'h0);
    pops = 0;
    for (int k = 0; k < 600 && q.size() != 0; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("drain_count", 64'(pops), 64'd386);
    checkOutput("drain_level", level, 0);

    // Random traffic across several pointer wraps.
    pops = 0;
    sent = 0;
    for (int k = 0; k < 8000 && pops < 1000; k++) begin
      applyStimulus((sent < 1000) && ($urandom_range(0, 3) != 0), 32'h1000_0000 + 32'(sent),
                    $urandom_range(0, 3) != 0, 0);
      if (acc) sent++;
    end
    checkOutput("wrap_count", 64'(pops), 64'd1000);
    checkOutput("wrap_level", level, 0);
    checkOutput("addr0_in_range", 64'(max0 <= DEPTH - 1), 64'd1);
    checkOutput("addr1_in_range", 64'(max1 <= DEPTH - 1), 64'd1);
    checkOutput("addr0_wrapped", wrap0, 1);
    checkOutput("addr1_wrapped", wrap1, 1);

    // Flush the cycle after a read issue; the returning word must be dropped.
    applyStimulus(1, 32'hA0, 0, 0);
    applyStimulus(1, 32'hB0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush_issue_seen", obs_csb1, 0);
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("flush_out_valid", obs_out_valid, 0);
      checkOutput("flush_level", obs_level, 0);
    end
    pops = 0;
    applyStimulus(1, 32'h1, 1, 0);
    for (int k = 0; k < 10 && pops == 0; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("flush_next_pops", 64'(pops), 64'd1);

    // Throughput: partial fill, then 500 cycles of continuous push and pop.
    n = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1, 32'h2000_0000 + 32'(n), 0, 0);
      if (acc) n++;
    end
    accepts = 0;
    pops = 0;
    for (int k = 0; k < 500; k++) begin
      applyStimulus(1, 32'h2000_0000 + 32'(n), 1, 0);
      if (acc) n++;
    end
    checkOutput("tput_accepts", 64'(accepts), 64'd500);
    checkOutput("tput_pops", 64'(pops), 64'd500);
    for (int k = 0; k < 300 && q.size() != 0; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("tput_drained", 64'(q.size()), 64'd0);
    checkOutput("tput_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
